// File: rtl/fp_cvt_dw_wb_if.sv
// Handshake bundle between the double-to-word converter, the writeback stage
// and the integer register-file write port.
interface fp_cvt_dw_wb_if #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [63:0]     in_d;
    logic            in_signed;
    logic [31:0]     in_w;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [RD_W-1:0] out_rd;
    logic [4:0]      out_fflags;
    logic [4:0]      fflags_acc;
    logic            fflags_clr;

    modport master (
        output in_valid, in_d, in_signed, in_w, in_rd, out_ready, fflags_clr,
        input  in_ready, out_valid, out_data, out_rd, out_fflags, fflags_acc
    );

    modport slave (
        input  in_valid, in_d, in_signed, in_w, in_rd, out_ready, fflags_clr,
        output in_ready, out_valid, out_data, out_rd, out_fflags, fflags_acc
    );
endinterface

// File: rtl/fp_cvt_dw_wb.sv
// FCVT.W[U].D writeback: NV/NX flag derivation, sign extension, 2-entry
// output FIFO and sticky fflags accumulation.
module fp_cvt_dw_wb #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input logic           clk,
    input logic           rst,
    fp_cvt_dw_wb_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic [4:0]      flags;
    } entry_t;

    logic              w_s;
    logic [10:0]       w_e;
    logic [51:0]       w_m;
    logic signed [12:0] w_ue;
    logic              w_nan_inf;
    logic              w_min_int;
    logic              w_nv_s;
    logic              w_nv_u;
    logic              w_nv;
    logic              w_nx;
    logic [51:0]       w_frac;
    entry_t            w_new;

    entry_t      r_head, r_tail;
    logic [1:0]  r_count;
    logic [4:0]  r_acc;
    entry_t      w_head_next, w_tail_next;
    logic [1:0]  w_count_next;
    logic [4:0]  w_acc_next;
    logic        w_push, w_pop, w_in_ready, w_out_valid;

    assign w_s  = bus.in_d[63];
    assign w_e  = bus.in_d[62:52];
    assign w_m  = bus.in_d[51:0];
    assign w_ue = $signed({2'b00, w_e}) - 13'sd1023;

    assign w_nan_inf = &w_e;
    // -2^31 is the only |x| >= 2^31 value that fits a signed word
    assign w_min_int = w_s && (w_e == 11'd1054) && (w_m == 52'd0);
    assign w_nv_s    = (w_ue >= 13'sd31) && !w_min_int;
    assign w_nv_u    = (!w_s && (w_ue >= 13'sd32)) || (w_s && (w_ue >= 13'sd0));
    assign w_nv      = w_nan_inf || (bus.in_signed ? w_nv_s : w_nv_u);

    // Shifting out the integer bits leaves only the fractional part of m
    assign w_frac = w_m << w_ue[5:0];

    always_comb begin
        w_nx = 1'b0;
        if (!w_nv) begin
            if (w_ue < 13'sd0)
                w_nx = |{w_e, w_m};
            else if (w_ue < 13'sd52)
                w_nx = |w_frac;
        end
    end

    assign w_new.data  = XLEN'($signed(bus.in_w));
    assign w_new.rd    = bus.in_rd;
    assign w_new.flags = {w_nv, 3'b000, w_nx};

    assign w_in_ready  = (r_count < 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_comb begin
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
            w_head_next = w_new;
        if (w_push && (r_count == 2'd1) && !w_pop)
            w_tail_next = w_new;
        if (w_pop && (r_count == 2'd2))
            w_head_next = r_tail;
        w_acc_next = (bus.fflags_clr ? 5'd0 : r_acc) | (w_pop ? r_head.flags : 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
            r_acc   <= 5'd0;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
            r_acc   <= w_acc_next;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = r_head.data;
    assign bus.out_rd     = r_head.rd;
    assign bus.out_fflags = r_head.flags;
    assign bus.fflags_acc = r_acc;
endmodule

// File: tb/tb_fp_cvt_dw_wb.sv
// Directed and randomized checks of fp_cvt_dw_wb against a real-arithmetic
// flag model and a queue-based FIFO model.
module tb_fp_cvt_dw_wb;
    localparam int XLEN = 64;
    localparam int RD_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_cvt_dw_wb_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    fp_cvt_dw_wb #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [4:0]  flags;
    } exp_t;

    exp_t       mq[$];
    logic [4:0] m_acc;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Flags from the real value: out-of-range -> NV, non-integer -> NX
    function automatic logic [4:0] ref_flags(input logic [63:0] d, input logic sgn);
        real x, t;
        logic nv;
        if (d[62:52] == 11'h7FF) return 5'h10;
        x = $bitstoreal(d);
        t = (x >= 0.0) ? $floor(x) : $ceil(x);
        if (sgn) nv = (x >= 2147483648.0) || (x < -2147483648.0);
        else     nv = (x >= 4294967296.0) || (x <= -1.0);
        if (nv) return 5'h10;
        return (x != t) ? 5'h01 : 5'h00;
    endfunction

    task automatic compare_all();
        check("in_ready", bus.in_ready, mq.size() < 2);
        check("out_valid", bus.out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_data", bus.out_data, mq[0].data);
            check("out_rd", bus.out_rd, mq[0].rd);
            check("out_fflags", bus.out_fflags, mq[0].flags);
        end
        check("fflags_acc", bus.fflags_acc, m_acc);
    endtask

    // Inputs are already driven (we sit at a negedge); advance one edge.
    task automatic tick();
        bit push, pop;
        exp_t e;
        push = bus.in_valid && (mq.size() < 2);
        pop  = (mq.size() != 0) && bus.out_ready;
        if (rst) begin
            mq.delete();
            m_acc = 5'd0;
        end else begin
            if (bus.fflags_clr) m_acc = 5'd0;
            if (pop) begin
                m_acc = m_acc | mq[0].flags;
                void'(mq.pop_front());
            end
            if (push) begin
                e.data  = {{32{bus.in_w[31]}}, bus.in_w};
                e.rd    = bus.in_rd;
                e.flags = ref_flags(bus.in_d, bus.in_signed);
                mq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic beat(input logic [63:0] d, input logic sgn, input logic [31:0] w,
                        input logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.in_d      = d;
        bus.in_signed = sgn;
        bus.in_w      = w;
        bus.in_rd     = rd;
    endtask

    function automatic logic [63:0] rand_double();
        logic [63:0] d;
        logic [63:0] m;
        logic [10:0] e;
        logic [63:0] corners [6];
        int r;
        corners[0] = 64'h41E0000000000000;
        corners[1] = 64'hC1E0000000000000;
        corners[2] = 64'hC1E0000000100000;
        corners[3] = 64'h41F0000000000000;
        corners[4] = 64'hBFF0000000000000;
        corners[5] = 64'h41EFFFFFFFE00000;
        r = $urandom_range(0, 11);
        if (r == 0) return corners[$urandom_range(0, 5)];
        m = {32'($urandom), 32'($urandom)};
        if ($urandom_range(0, 1) == 1) m = m & (~64'h0 << $urandom_range(20, 52));
        if (r == 1)      e = 11'd0;
        else if (r == 2) e = 11'h7FF;
        else             e = 11'(1021 + $urandom_range(0, 58));
        if (r == 1 && $urandom_range(0, 1) == 1) m = 64'd0;
        d = {1'($urandom), e, m[51:0]};
        return d;
    endfunction

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_d = '0; bus.in_signed = 1'b0;
        bus.in_w = '0; bus.in_rd = '0; bus.out_ready = 1'b0; bus.fflags_clr = 1'b0;
        mq.delete();
        m_acc = 5'd0;
        @(negedge clk);
        tick();
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_rd", bus.out_rd, 64'd0);
        check("rst_out_fflags", bus.out_fflags, 64'd0);
        rst = 1'b0;

        // 2147483647.0 signed
        bus.out_ready = 1'b1;
        beat(64'h41DFFFFFFFC00000, 1'b1, 32'h7FFFFFFF, 5'd4);
        tick();
        check("t1_data", bus.out_data, 64'h000000007FFFFFFF);
        check("t1_flags", bus.out_fflags, 64'h00);
        bus.in_valid = 1'b0;
        tick();

        // 1.5 signed -> NX
        beat(64'h3FF8000000000000, 1'b1, 32'd1, 5'd5);
        tick();
        check("t2_data", bus.out_data, 64'd1);
        check("t2_flags", bus.out_fflags, 64'h01);
        bus.in_valid = 1'b0;
        tick();
        check("t2_acc", bus.fflags_acc, 64'h01);

        // signed boundaries -2^31 and 2^31
        beat(64'hC1E0000000000000, 1'b1, 32'h80000000, 5'd6);
        tick();
        check("t3_data", bus.out_data, 64'hFFFFFFFF80000000);
        check("t3_flags", bus.out_fflags, 64'h00);
        beat(64'h41E0000000000000, 1'b1, 32'h7FFFFFFF, 5'd7);
        tick();
        check("t3b_flags", bus.out_fflags, 64'h10);

        // unsigned -0.5, -1.0, NaN
        beat(64'hBFE0000000000000, 1'b0, 32'd0, 5'd8);
        tick();
        check("t4a_flags", bus.out_fflags, 64'h01);
        beat(64'hBFF0000000000000, 1'b0, 32'd0, 5'd9);
        tick();
        check("t4b_flags", bus.out_fflags, 64'h10);
        beat(64'h7FF8000000000000, 1'b0, 32'hFFFFFFFF, 5'd10);
        tick();
        check("t4c_flags", bus.out_fflags, 64'h10);
        bus.in_valid = 1'b0;
        bus.fflags_clr = 1'b1;
        tick();
        bus.fflags_clr = 1'b0;

        // backpressure, three beats offered
        bus.out_ready = 1'b0;
        beat(64'h4000000000000000, 1'b1, 32'd2, 5'd1);
        tick();
        bus.in_rd = 5'd2;
        tick();
        check("t5_ready_full", bus.in_ready, 64'd0);
        bus.in_rd = 5'd3;
        tick();
        check("t5_head", bus.out_rd, 64'd1);
        bus.out_ready = 1'b1;
        tick();
        check("t5_pop1_rd", bus.out_rd, 64'd2);
        check("t5_ready_back", bus.in_ready, 64'd1);
        tick();
        check("t5_pop2_rd", bus.out_rd, 64'd3);
        bus.in_valid = 1'b0;
        tick();
        check("t5_empty", bus.out_valid, 64'd0);

        // pop with simultaneous clear, then reset with two entries queued
        bus.out_ready = 1'b0;
        beat(64'h41E0000000000000, 1'b1, 32'h7FFFFFFF, 5'd11);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.fflags_clr = 1'b1;
        tick();
        check("t6_acc", bus.fflags_acc, 64'h10);
        bus.fflags_clr = 1'b0;
        bus.out_ready = 1'b0;
        beat(64'h3FF8000000000000, 1'b1, 32'd1, 5'd12);
        tick();
        tick();
        check("t6_full", bus.in_ready, 64'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t6_rst_valid", bus.out_valid, 64'd0);
        check("t6_rst_acc", bus.fflags_acc, 64'd0);
        check("t6_rst_ready", bus.in_ready, 64'd1);
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                beat(rand_double(), 1'($urandom), 32'($urandom), 5'($urandom));
            else
                bus.in_valid = 1'b0;
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            bus.fflags_clr = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
